// File: rtl/mult_div_unit_pkg.sv
// Shared constants for the iterative multiply/divide unit: default width,
// operation encodings and FSM state codes.
package mult_div_unit_pkg;

    localparam int WIDTH_DEF = 32;

    // Op[1] selects divide, Op[0] selects signed arithmetic.
    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit feeding architectural Hi/Lo registers.
// Shift-add multiply and restoring divide, one bit per clock, on magnitudes;
// sign correction is applied in a final FIX cycle.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] OperandA,
    input  logic [WIDTH-1:0] OperandB,
    input  logic             MtHiEn,
    input  logic             MtLoEn,
    input  logic [WIDTH-1:0] MtData,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return ~v + WIDTH'(1);
    endfunction

    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? negate(v) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] negate_wide(input logic [2*WIDTH-1:0] v);
        return ~v + (2*WIDTH)'(1);
    endfunction

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic               is_div;
    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   orig_a;
    // Multiplicand for multiply, divisor for divide.
    logic [WIDTH-1:0]   addend;
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits / quotient bits}.
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic               done;
    logic               dz;

    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     add_x;
    logic [WIDTH:0]     add_y;
    logic               add_cin;
    logic [WIDTH+1:0]   add_res;
    logic               quo_bit;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;
    logic               fix_dz;

    assign acc_hi = acc[2*WIDTH-1:WIDTH];
    assign acc_lo = acc[WIDTH-1:0];
    assign a_mag  = Op[0] ? abs_val(OperandA) : OperandA;
    assign b_mag  = Op[0] ? abs_val(OperandB) : OperandB;

    // Shared adder: add for multiply, trial subtract (x + ~y + 1) for divide.
    always_comb begin
        add_x   = {1'b0, acc_hi};
        add_y   = {1'b0, addend};
        add_cin = 1'b0;
        if (is_div) begin
            add_x   = {acc_hi, acc_lo[WIDTH-1]};
            add_y   = ~{1'b0, addend};
            add_cin = 1'b1;
        end
        add_res = {1'b0, add_x} + {1'b0, add_y} + {{(WIDTH+1){1'b0}}, add_cin};
    end

    // Carry out of the trial subtract means the shifted remainder >= divisor.
    assign quo_bit = add_res[WIDTH+1];

    // One iteration of shift-add multiply or restoring divide.
    always_comb begin
        acc_next = acc;
        if (is_div) begin
            acc_next = {(quo_bit ? add_res[WIDTH-1:0] : {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]}),
                        acc_lo[WIDTH-2:0], quo_bit};
        end else if (acc[0]) begin
            acc_next = {add_res[WIDTH:0], acc_lo[WIDTH-1:1]};
        end else begin
            acc_next = {1'b0, acc_hi, acc_lo[WIDTH-1:1]};
        end
    end

    // Sign correction and divide-by-zero substitution applied at FIX.
    always_comb begin
        fix_hi = acc_hi;
        fix_lo = acc_lo;
        fix_dz = 1'b0;
        if (!is_div) begin
            {fix_hi, fix_lo} = (sign_a ^ sign_b) ? negate_wide(acc) : acc;
        end else if (addend == '0) begin
            fix_hi = orig_a;
            fix_lo = '1;
            fix_dz = 1'b1;
        end else begin
            fix_lo = (sign_a ^ sign_b) ? negate(acc_lo) : acc_lo;
            fix_hi = sign_a ? negate(acc_hi) : acc_hi;
        end
    end

    // FSM, iteration counter, datapath registers and Hi/Lo.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            is_div <= 1'b0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            orig_a <= '0;
            addend <= '0;
            acc    <= '0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
            dz     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (MtHiEn) hi <= MtData;
                    if (MtLoEn) lo <= MtData;
                    if (Start) begin
                        state  <= ST_CALC;
                        cnt    <= '0;
                        is_div <= Op[1];
                        sign_a <= Op[0] & OperandA[WIDTH-1];
                        sign_b <= Op[0] & OperandB[WIDTH-1];
                        orig_a <= OperandA;
                        addend <= Op[1] ? b_mag : a_mag;
                        acc    <= {{WIDTH{1'b0}}, (Op[1] ? a_mag : b_mag)};
                        dz     <= 1'b0;
                    end
                end
                ST_CALC: begin
                    acc <= acc_next;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST_ITER) state <= ST_FIX;
                end
                ST_FIX: begin
                    hi    <= fix_hi;
                    lo    <= fix_lo;
                    dz    <= fix_dz;
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign Busy      = (state != ST_IDLE);
    assign Done      = done;
    assign DivByZero = dz;
    assign Hi        = hi;
    assign Lo        = lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: the driver pushes reference results,
// a negedge monitor pops and compares whenever Done is presented.
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          Start;
    logic [1:0]    Op;
    logic [W-1:0]  OperandA;
    logic [W-1:0]  OperandB;
    logic          MtHiEn;
    logic          MtLoEn;
    logic [W-1:0]  MtData;
    logic          Busy;
    logic          Done;
    logic          DivByZero;
    logic [W-1:0]  Hi;
    logic [W-1:0]  Lo;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .Start(Start), .Op(Op),
        .OperandA(OperandA), .OperandB(OperandB),
        .MtHiEn(MtHiEn), .MtLoEn(MtLoEn), .MtData(MtData),
        .Busy(Busy), .Done(Done), .DivByZero(DivByZero), .Hi(Hi), .Lo(Lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        bit           dz;
        int           e0;
    } exp_t;

    exp_t          sb_q[$];
    int            total = 0;
    int            bad   = 0;
    int            cyc   = 0;
    logic [W-1:0]  cur_hi = '0;
    logic [W-1:0]  cur_lo = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic on the architectural rules.
    task automatic model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output exp_t e);
        logic [63:0]        pu;
        logic signed [63:0] ps;
        int signed          sa, sb;
        e.dz = 0;
        case (op)
            OP_MULTU: begin
                pu = {32'b0, a} * {32'b0, b};
                {e.hi, e.lo} = pu;
            end
            OP_MULT: begin
                ps = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                {e.hi, e.lo} = ps;
            end
            default: begin
                if (b == 0) begin
                    e.lo = '1; e.hi = a; e.dz = 1;
                end else if (op == OP_DIVU) begin
                    e.lo = a / b; e.hi = a % b;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    e.lo = 32'h8000_0000; e.hi = 0;
                end else begin
                    sa = a; sb = b;
                    e.lo = sa / sb; e.hi = sa % sb;
                end
            end
        endcase
    endtask

    // Monitor: every Done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (Done) begin
            if (sb_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_done: got Done=1 expected no result pending (t=%0t)", $time);
            end else begin
                e = sb_q.pop_front();
                chk("hi", Hi, e.hi);
                chk("lo", Lo, e.lo);
                chk("div_by_zero", DivByZero, e.dz);
                // Start edge E0 to the FIX edge E33; Done is seen in the cycle after E33.
                chk("latency_edges", cyc - e.e0, 33);
                chk("busy_with_done", Busy, 0);
                cur_hi = e.hi;
                cur_lo = e.lo;
            end
        end
    end

    // Called at a negedge; Start is sampled at the next rising edge (E0).
    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit expect_res);
        exp_t e;
        model(op, a, b, e);
        e.e0 = cyc + 1;
        Start = 1; Op = op; OperandA = a; OperandB = b;
        if (expect_res) sb_q.push_back(e);
        @(negedge clk);
        Start = 0; MtHiEn = 0; MtLoEn = 0;
        chk("busy_after_start", Busy, 1);
        chk("dz_cleared_on_start", DivByZero, 0);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!Done && n < 80) begin
            @(negedge clk);
            n++;
        end
        if (!Done) begin
            total++; bad++;
            $display("FAIL done_timeout: got no Done within %0d cycles expected Done", n);
        end
    endtask

    task automatic run(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        issue(op, a, b, 1);
        wait_done();
    endtask

    initial begin
        logic [1:0]   rop;
        logic [W-1:0] ra, rb;
        rst_n = 0; Start = 0; Op = 0; OperandA = 0; OperandB = 0;
        MtHiEn = 0; MtLoEn = 0; MtData = 0;
        repeat (2) @(negedge clk);
        chk("rst_hi", Hi, 0);
        chk("rst_lo", Lo, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_dz", DivByZero, 0);
        rst_n = 1;
        @(negedge clk);

        // Directed corner operations, issued back to back.
        run(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run(OP_MULT,  32'hFFFF_FFFD, 32'd7);
        run(OP_MULT,  32'h8000_0000, 32'h8000_0000);
        run(OP_DIV,   32'hFFFF_FFF9, 32'd2);
        run(OP_DIVU,  32'd100, 32'd7);
        run(OP_DIVU,  32'd100, 32'd0);
        run(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
        run(OP_DIV,   32'hFFFF_FF00, 32'd0);
        run(OP_DIV,   32'd17, 32'hFFFF_FFFB);
        @(negedge clk);

        // MTLO in IDLE updates Lo only.
        MtLoEn = 1; MtData = 32'h0000_ABCD;
        @(negedge clk);
        MtLoEn = 0;
        chk("mtlo_lo", Lo, 32'h0000_ABCD);
        chk("mtlo_hi_kept", Hi, cur_hi);
        cur_lo = 32'h0000_ABCD;

        // Start and MTHI while busy are both ignored.
        issue(OP_MULTU, 32'd3, 32'd5, 1);
        repeat (3) @(negedge clk);
        Start = 1; Op = OP_DIVU; OperandA = 32'd9; OperandB = 32'd0;
        MtHiEn = 1; MtData = 32'h0000_1234;
        @(negedge clk);
        Start = 0; MtHiEn = 0;
        chk("mthi_ignored_busy", Hi, cur_hi);
        chk("busy_still", Busy, 1);
        wait_done();
        repeat (40) @(negedge clk);
        chk("idle_after_ignored_start", Busy, 0);

        // Mt write coinciding with an accepted Start lands, then the result overwrites it.
        MtLoEn = 1; MtData = 32'h0000_0055;
        issue(OP_MULTU, 32'd2, 32'd3, 1);
        chk("mt_with_start", Lo, 32'h0000_0055);
        wait_done();
        @(negedge clk);

        // Reset in the middle of a divide aborts it with no partial result.
        issue(OP_DIV, 32'hFFFF_FF9C, 32'd3, 0);
        repeat (9) @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        chk("abort_busy", Busy, 0);
        chk("abort_done", Done, 0);
        chk("abort_hi", Hi, 0);
        chk("abort_lo", Lo, 0);
        chk("abort_dz", DivByZero, 0);
        cur_hi = 0; cur_lo = 0;
        repeat (40) @(negedge clk);
        run(OP_MULTU, 32'd6, 32'd7);

        // Randomised operations with occasional zero divisors and small operands.
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            if ($urandom_range(0, 7) == 0) rb = 0;
            if ($urandom_range(0, 3) == 0) ra = ra >> $urandom_range(0, 31);
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
            run(rop, ra, rb);
        end

        repeat (3) @(negedge clk);
        if (sb_q.size() != 0) begin
            total++; bad++;
            $display("FAIL results_missing: got %0d pending expected 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
